// File: rtl/unified_mem_arbiter.sv
// Arbitrates a single-ported unified memory between fetch and data requesters.
// Data has priority; a starvation counter forces a fetch grant after MAX_DWAIT data wins.
module unified_mem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_LAT   = 1,
    parameter int MAX_DWAIT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              busy
);

    typedef enum logic {IDLE, BUSY} state_t;
    typedef enum logic {OWN_IF, OWN_DM} owner_t;

    localparam logic [1:0] LAT_RELOAD = 2'(MEM_LAT - 1);
    localparam logic [2:0] DWAIT_MAX  = 3'(MAX_DWAIT);

    state_t     state, state_next;
    owner_t     owner, owner_next;
    logic       is_wr, is_wr_next;
    logic [1:0] lat_cnt, lat_cnt_next;
    logic [2:0] dwait_cnt, dwait_next;
    logic       live, gnt_if, gnt_dm, resp, pending;

    // Outputs are forced quiet while rst is high, so nothing is granted during reset.
    assign live   = !rst && ((state == IDLE) || (lat_cnt == 2'd0));
    assign gnt_dm = live && dm_req && !(if_req && (dwait_cnt == DWAIT_MAX));
    assign gnt_if = live && if_req && !gnt_dm;
    assign resp   = !rst && (state == BUSY) && (lat_cnt == 2'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= OWN_IF;
            is_wr     <= 1'b0;
            lat_cnt   <= 2'd0;
            dwait_cnt <= 3'd0;
        end else begin
            state     <= state_next;
            owner     <= owner_next;
            is_wr     <= is_wr_next;
            lat_cnt   <= lat_cnt_next;
            dwait_cnt <= dwait_next;
        end
    end

    always_comb begin
        state_next   = state;
        owner_next   = owner;
        is_wr_next   = is_wr;
        lat_cnt_next = lat_cnt;
        dwait_next   = dwait_cnt;
        if (gnt_if || gnt_dm) begin
            state_next   = BUSY;
            owner_next   = gnt_dm ? OWN_DM : OWN_IF;
            is_wr_next   = gnt_dm && dm_we;
            lat_cnt_next = LAT_RELOAD;
        end else if (state == BUSY) begin
            if (lat_cnt == 2'd0) begin
                state_next = IDLE;
            end else begin
                lat_cnt_next = lat_cnt - 2'd1;
            end
        end
        if (!if_req || gnt_if) begin
            dwait_next = 3'd0;
        end else if (gnt_dm && (dwait_cnt != DWAIT_MAX)) begin
            dwait_next = dwait_cnt + 3'd1;
        end
    end

    always_comb begin
        if_gnt    = gnt_if;
        dm_gnt    = gnt_dm;
        mem_en    = gnt_if || gnt_dm;
        mem_we    = gnt_dm && dm_we;
        mem_addr  = gnt_dm ? dm_addr : (gnt_if ? if_addr : '0);
        mem_wdata = (gnt_dm && dm_we) ? dm_wdata : '0;
        if_rvalid = resp && (owner == OWN_IF);
        dm_rvalid = resp && (owner == OWN_DM);
        if_rdata  = if_rvalid ? mem_rdata : '0;
        dm_rdata  = (dm_rvalid && !is_wr) ? mem_rdata : '0;
        // A write stops stalling the memory stage right after its grant.
        pending   = !rst && (state == BUSY) && (lat_cnt != 2'd0);
        stall_if  = (!rst && if_req && !gnt_if) || (pending && (owner == OWN_IF));
        stall_mem = (!rst && dm_req && !gnt_dm) || (pending && (owner == OWN_DM) && !is_wr);
        busy      = !rst && (state == BUSY);
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: three instances (MEM_LAT 1..3) checked every cycle
// against a timestamp-based reference model, plus directed scenarios.
module tb_unified_mem_arbiter;

    localparam int N_INST    = 3;
    localparam int MAX_DWAIT = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [N_INST-1:0]       rst_s, if_req_s, dm_req_s, dm_we_s;
    logic [N_INST-1:0][31:0] if_addr_s, dm_addr_s, dm_wdata_s, mem_rdata_s;
    logic [N_INST-1:0]       if_gnt_s, if_rvalid_s, dm_gnt_s, dm_rvalid_s;
    logic [N_INST-1:0]       mem_en_s, mem_we_s, stall_if_s, stall_mem_s, busy_s;
    logic [N_INST-1:0][31:0] if_rdata_s, dm_rdata_s, mem_addr_s, mem_wdata_s;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model: one outstanding transaction per instance, described by its due cycle.
    int          m_due   [N_INST];
    logic        m_port  [N_INST];
    logic        m_wr    [N_INST];
    logic [31:0] m_data  [N_INST];
    int          m_dwait [N_INST];
    logic        e_if_gnt[N_INST];
    logic        e_dm_gnt[N_INST];
    logic [31:0] shadow  [int];

    function automatic logic [31:0] init_word(input int g, input int a);
        if (g == 1 && a == 'h100) return 32'h00500093;
        return 32'hC0DE0000 ^ 32'(a * 40503) ^ 32'(g << 28);
    endfunction

    for (genvar g = 0; g < N_INST; g++) begin : g_inst
        logic [31:0] wr_map [int];
        logic [31:0] rd_q = '0;
        logic [31:0] junk = '0;
        int          cnt  = 0;

        unified_mem_arbiter #(
            .ADDR_W(32), .DATA_W(32), .MEM_LAT(g + 1), .MAX_DWAIT(MAX_DWAIT)
        ) u_dut (
            .clk(clk), .rst(rst_s[g]),
            .if_req(if_req_s[g]), .if_addr(if_addr_s[g]), .if_gnt(if_gnt_s[g]),
            .if_rvalid(if_rvalid_s[g]), .if_rdata(if_rdata_s[g]),
            .dm_req(dm_req_s[g]), .dm_we(dm_we_s[g]), .dm_addr(dm_addr_s[g]),
            .dm_wdata(dm_wdata_s[g]), .dm_gnt(dm_gnt_s[g]),
            .dm_rvalid(dm_rvalid_s[g]), .dm_rdata(dm_rdata_s[g]),
            .mem_en(mem_en_s[g]), .mem_we(mem_we_s[g]), .mem_addr(mem_addr_s[g]),
            .mem_wdata(mem_wdata_s[g]), .mem_rdata(mem_rdata_s[g]),
            .stall_if(stall_if_s[g]), .stall_mem(stall_mem_s[g]), .busy(busy_s[g])
        );

        // Memory returns read data exactly g+1 cycles after issue, random junk otherwise.
        always @(posedge clk) begin
            junk <= $urandom;
            if (cnt > 0) cnt <= cnt - 1;
            if (mem_en_s[g]) begin
                if (mem_we_s[g]) begin
                    wr_map[int'(mem_addr_s[g])] = mem_wdata_s[g];
                end else begin
                    rd_q <= wr_map.exists(int'(mem_addr_s[g])) ? wr_map[int'(mem_addr_s[g])]
                                                               : init_word(g, int'(mem_addr_s[g]));
                    cnt  <= g + 1;
                end
            end
        end
        assign mem_rdata_s[g] = (cnt == 1) ? rd_q : junk;
    end

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("[TB] FAIL %s inst%0d cycle %0d: observed %h, expected %h", tag, k, cyc, obs, exp);
        end
    endtask

    task automatic check_output(input int k);
        logic        ig, dg, irv, drv, en, we, si, sm, bsy, resp, live;
        logic [31:0] ird, drd, addr, wd;
        int          key;
        ig = 0; dg = 0; irv = 0; drv = 0; en = 0; we = 0; si = 0; sm = 0; bsy = 0;
        ird = '0; drd = '0; addr = '0; wd = '0;
        if (rst_s[k]) begin
            m_due[k]   = -1;
            m_dwait[k] = 0;
        end else begin
            resp = (m_due[k] == cyc);
            live = (m_due[k] < 0) || resp;
            bsy  = (m_due[k] >= 0);
            if (resp && m_port[k])  begin drv = 1; drd = m_wr[k] ? 32'd0 : m_data[k]; end
            if (resp && !m_port[k]) begin irv = 1; ird = m_data[k]; end
            si = (m_due[k] > cyc) && !m_port[k];
            sm = (m_due[k] > cyc) && m_port[k] && !m_wr[k];
            if (live) begin
                dg = dm_req_s[k] && !(if_req_s[k] && m_dwait[k] == MAX_DWAIT);
                ig = if_req_s[k] && !dg;
            end
            si = si || (if_req_s[k] && !ig);
            sm = sm || (dm_req_s[k] && !dg);
            if (dg || ig) begin
                en   = 1;
                we   = dg && dm_we_s[k];
                addr = dg ? dm_addr_s[k] : if_addr_s[k];
                wd   = we ? dm_wdata_s[k] : 32'd0;
                key  = k * 65536 + int'(addr[15:0]);
                m_due[k]  = cyc + k + 1;
                m_port[k] = dg;
                m_wr[k]   = we;
                if (we) shadow[key] = wd;
                else m_data[k] = shadow.exists(key) ? shadow[key] : init_word(k, int'(addr[15:0]));
            end else if (resp) begin
                m_due[k] = -1;
            end
            if (!if_req_s[k] || ig) m_dwait[k] = 0;
            else if (dg && m_dwait[k] < MAX_DWAIT) m_dwait[k]++;
        end
        e_if_gnt[k] = ig;
        e_dm_gnt[k] = dg;
        chk("if_gnt", k, if_gnt_s[k], ig);
        chk("dm_gnt", k, dm_gnt_s[k], dg);
        chk("if_rvalid", k, if_rvalid_s[k], irv);
        chk("if_rdata", k, if_rdata_s[k], ird);
        chk("dm_rvalid", k, dm_rvalid_s[k], drv);
        chk("dm_rdata", k, dm_rdata_s[k], drd);
        chk("mem_en", k, mem_en_s[k], en);
        chk("mem_we", k, mem_we_s[k], we);
        chk("mem_addr", k, mem_addr_s[k], addr);
        chk("mem_wdata", k, mem_wdata_s[k], wd);
        chk("stall_if", k, stall_if_s[k], si);
        chk("stall_mem", k, stall_mem_s[k], sm);
        chk("busy", k, busy_s[k], bsy);
    endtask

    task automatic step_check();
        @(negedge clk);
        for (int k = 0; k < N_INST; k++) check_output(k);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drop_granted();
        for (int k = 0; k < N_INST; k++) begin
            if (e_if_gnt[k]) if_req_s[k] = 1'b0;
            if (e_dm_gnt[k]) dm_req_s[k] = 1'b0;
        end
    endtask

    task automatic tick(input bit drop);
        step_check();
        next_cycle();
        if (drop) drop_granted();
    endtask

    task automatic reset_all(input int n);
        rst_s = '1; if_req_s = '0; dm_req_s = '0; dm_we_s = '0;
        repeat (n) tick(0);
        rst_s = '0;
    endtask

    task automatic apply_stimulus(input int k);
        if (if_req_s[k] && e_if_gnt[k]) if_req_s[k] = 1'b0;
        if (dm_req_s[k] && e_dm_gnt[k]) dm_req_s[k] = 1'b0;
        if (!if_req_s[k]) begin
            if ($urandom_range(0, 2) != 0) begin
                if_req_s[k]  = 1'b1;
                if_addr_s[k] = 32'($urandom_range(0, 63) * 4);
            end
        end else if ($urandom_range(0, 15) == 0) begin
            if_req_s[k] = 1'b0;
        end
        if (!dm_req_s[k]) begin
            if ($urandom_range(0, 2) != 0) begin
                dm_req_s[k]   = 1'b1;
                dm_we_s[k]    = 1'($urandom_range(0, 1));
                dm_addr_s[k]  = 32'($urandom_range(0, 63) * 4);
                dm_wdata_s[k] = $urandom;
            end
        end else if ($urandom_range(0, 15) == 0) begin
            dm_req_s[k] = 1'b0;
        end
        rst_s[k] = ($urandom_range(0, 63) == 0);
    endtask

    logic [7:0] f_seq;

    initial begin
        f_seq = 8'b1000_1000;
        rst_s = '1; if_req_s = '1; dm_req_s = '1; dm_we_s = '0;
        for (int k = 0; k < N_INST; k++) begin
            if_addr_s[k] = 32'h10; dm_addr_s[k] = 32'h20; dm_wdata_s[k] = '0;
            m_due[k] = -1; m_dwait[k] = 0; m_port[k] = 0; m_wr[k] = 0; m_data[k] = '0;
            e_if_gnt[k] = 0; e_dm_gnt[k] = 0;
        end

        $display("[TB] reset with both requests high");
        repeat (3) begin
            step_check();
            for (int k = 0; k < N_INST; k++) begin
                chk("rst_flags", k, {if_gnt_s[k], dm_gnt_s[k], if_rvalid_s[k], dm_rvalid_s[k], mem_en_s[k],
                                     mem_we_s[k], stall_if_s[k], stall_mem_s[k], busy_s[k]}, 32'd0);
                chk("rst_mem_addr", k, mem_addr_s[k], 32'd0);
            end
            next_cycle();
        end
        rst_s = '0;
        step_check();
        for (int k = 0; k < N_INST; k++) begin
            chk("first_dm_gnt", k, dm_gnt_s[k], 1'b1);
            chk("first_if_gnt", k, if_gnt_s[k], 1'b0);
        end
        next_cycle(); drop_granted();
        repeat (8) tick(1);

        $display("[TB] fetch alone, MEM_LAT=2");
        reset_all(2);
        if_req_s[1] = 1'b1; if_addr_s[1] = 32'h100;
        step_check();
        chk("fa_gnt", 1, if_gnt_s[1], 1'b1);
        chk("fa_en", 1, mem_en_s[1], 1'b1);
        chk("fa_addr", 1, mem_addr_s[1], 32'h100);
        next_cycle(); drop_granted();
        step_check();
        chk("fa_rvalid_c1", 1, if_rvalid_s[1], 1'b0);
        chk("fa_stall_c1", 1, stall_if_s[1], 1'b1);
        next_cycle();
        step_check();
        chk("fa_rvalid_c2", 1, if_rvalid_s[1], 1'b1);
        chk("fa_rdata_c2", 1, if_rdata_s[1], 32'h00500093);
        next_cycle();
        step_check();
        chk("fa_rvalid_c3", 1, if_rvalid_s[1], 1'b0);
        next_cycle();

        $display("[TB] collision, MEM_LAT=1");
        reset_all(2);
        if_req_s[0] = 1'b1; if_addr_s[0] = 32'h4;
        dm_req_s[0] = 1'b1; dm_we_s[0] = 1'b0; dm_addr_s[0] = 32'h80;
        step_check();
        chk("col_dm_gnt_c0", 0, dm_gnt_s[0], 1'b1);
        chk("col_if_gnt_c0", 0, if_gnt_s[0], 1'b0);
        next_cycle(); drop_granted();
        step_check();
        chk("col_if_gnt_c1", 0, if_gnt_s[0], 1'b1);
        chk("col_dm_rvalid_c1", 0, dm_rvalid_s[0], 1'b1);
        chk("col_dm_rdata_c1", 0, dm_rdata_s[0], init_word(0, 'h80));
        next_cycle(); drop_granted();
        step_check();
        chk("col_if_rvalid_c2", 0, if_rvalid_s[0], 1'b1);
        chk("col_if_rdata_c2", 0, if_rdata_s[0], init_word(0, 'h4));
        next_cycle();

        $display("[TB] starvation, MEM_LAT=1");
        reset_all(2);
        if_req_s[0] = 1'b1; dm_req_s[0] = 1'b1; dm_we_s[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step_check();
            chk("starve_if_gnt", 0, if_gnt_s[0], f_seq[i]);
            chk("starve_dm_gnt", 0, dm_gnt_s[0], !f_seq[i]);
            next_cycle();
        end
        if_req_s[0] = 1'b0; dm_req_s[0] = 1'b0;
        repeat (2) tick(0);

        $display("[TB] write then read back, MEM_LAT=3");
        reset_all(2);
        dm_req_s[2] = 1'b1; dm_we_s[2] = 1'b1; dm_addr_s[2] = 32'h40; dm_wdata_s[2] = 32'hDEADBEEF;
        step_check();
        chk("wr_gnt", 2, dm_gnt_s[2], 1'b1);
        chk("wr_en", 2, mem_en_s[2], 1'b1);
        chk("wr_we", 2, mem_we_s[2], 1'b1);
        chk("wr_wdata", 2, mem_wdata_s[2], 32'hDEADBEEF);
        next_cycle(); drop_granted();
        step_check();
        chk("wr_stall_c1", 2, stall_mem_s[2], 1'b0);
        next_cycle();
        tick(0);
        step_check();
        chk("wr_ack", 2, dm_rvalid_s[2], 1'b1);
        chk("wr_ack_data", 2, dm_rdata_s[2], 32'd0);
        next_cycle();
        dm_req_s[2] = 1'b1; dm_we_s[2] = 1'b0;
        tick(1);
        repeat (2) tick(0);
        step_check();
        chk("rb_rvalid", 2, dm_rvalid_s[2], 1'b1);
        chk("rb_rdata", 2, dm_rdata_s[2], 32'hDEADBEEF);
        next_cycle();

        $display("[TB] reset mid-read, MEM_LAT=3");
        dm_req_s[2] = 1'b1; dm_we_s[2] = 1'b0; dm_addr_s[2] = 32'h20;
        step_check();
        chk("mr_gnt", 2, dm_gnt_s[2], 1'b1);
        next_cycle(); drop_granted();
        rst_s[2] = 1'b1;
        tick(0);
        rst_s[2] = 1'b0;
        step_check();
        chk("mr_busy_c2", 2, busy_s[2], 1'b0);
        next_cycle();
        step_check();
        chk("mr_rvalid_c3", 2, dm_rvalid_s[2], 1'b0);
        chk("mr_busy_c3", 2, busy_s[2], 1'b0);
        next_cycle();

        $display("[TB] randomized traffic on all instances");
        reset_all(2);
        for (int c = 0; c < 3000; c++) begin
            step_check();
            next_cycle();
            for (int k = 0; k < N_INST; k++) apply_stimulus(k);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

Shares a single-ported unified instruction/data memory between the pipeline's fetch stage and its memory stage. It arbitrates per transaction, drives the memory port, tracks the fixed read latency, and returns responses to the correct requester. Stall signals go back to the hazard logic. The data port has priority; a bounded starvation counter guarantees that fetch makes forward progress.

## Interface
- ADDR_W, 32, address width of both requesters and the memory port
- DATA_W, 32, data width
- MEM_LAT, 1, cycles from issue to valid `mem_rdata`; legal range 1..4
- MAX_DWAIT, 3, max consecutive data grants while fetch is waiting; legal range 1..7

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset; synchronous, active-high
- if_req  in  1  fetch request; held with stable `if_addr` until `if_gnt`
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch request issued this cycle
- if_rvalid  out  1  fetch read data valid, one-cycle pulse
- if_rdata  out  DATA_W  fetch read data; 0 when `if_rvalid`=0
- dm_req  in  1  data request; held with stable `dm_we`/`dm_addr`/`dm_wdata` until `dm_gnt`
- dm_we  in  1  1 = write, 0 = read
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  write data
- dm_gnt  out  1  data request issued this cycle
- dm_rvalid  out  1  data response pulse (read data or write ack)
- dm_rdata  out  DATA_W  read data; 0 for write acks and when `dm_rvalid`=0
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable, qualified by `mem_en`
- mem_addr  out  ADDR_W  memory address; 0 when `mem_en`=0
- mem_wdata  out  DATA_W  memory write data; 0 when `mem_en`=0 or `mem_we`=0
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after issue
- stall_if  out  1  `if_req & ~if_gnt`, or a fetch transaction is outstanding
- stall_mem  out  1  `dm_req & ~dm_gnt`, or a data transaction is outstanding
- busy  out  1  FSM not in IDLE

## Operation
- FSM states:
  - IDLE: no transaction in flight.
  - BUSY: one transaction outstanding. Registers: `owner` (IF/DM), `is_wr`, `lat_cnt` (2 bits).
- Arbitration is live, i.e. a grant may be issued, when:
  - state = IDLE, or
  - state = BUSY and `lat_cnt` = 0 (the response cycle). This gives back-to-back issue.
- Grant decision (combinational, at most one grant per cycle):
  - Only `dm_req`: grant DM.
  - Only `if_req`: grant IF.
  - Both: grant IF if `dwait_cnt` = MAX_DWAIT, otherwise grant DM.
- `dwait_cnt`:
  - Increments on a DM grant while `if_req`=1.
  - Clears on an IF grant or whenever `if_req`=0.
  - Saturates at MAX_DWAIT.
- Grant cycle:
  - `gnt` pulses high for the winning port.
  - `mem_en`=1; `mem_addr`/`mem_we`/`mem_wdata` come from the winner's inputs.
  - Next state is BUSY with `lat_cnt`=MEM_LAT-1 and `owner`/`is_wr` captured.
- BUSY with `lat_cnt` > 0: decrement; no arbitration; `mem_en`=0.
- BUSY with `lat_cnt` = 0:
  - The owner's `rvalid` pulses.
  - `rdata` = `mem_rdata` for a read, 0 for a write.
  - If a new grant occurs, reload BUSY; otherwise go to IDLE.
- A request deasserted before its grant is cancelled silently. This is legal; the fetch stage uses it on a branch flush.
- Reset values:
  - Every output is 0.
  - State = IDLE; `lat_cnt`, `dwait_cnt`, `owner` and `is_wr` are 0.
- Reset asserted mid-transaction: the in-flight transaction is abandoned and no `rvalid` is ever produced for it. Arbitration resumes in the first cycle after `rst` deasserts.

## Timing
- Issue cycle T: `gnt` and `mem_en` are combinational from the requests and registered state. No registered delay.
- Response at cycle T+MEM_LAT. `rdata` is passed combinationally from `mem_rdata` in that cycle.
- Throughput: one transaction per MEM_LAT cycles, with no bubble between transactions.
- Each transaction produces exactly one `rvalid` (barring reset), delivered to the port that was granted.
- `stall_if`/`stall_mem` are high from request until the cycle before the response. For a write, `stall_mem` clears in the cycle after grant, and the write ack is informational.

## Test plan
- Reset: hold `rst`=1 for 3 cycles with both requests high -> every output is 0 throughout. First grant to DM occurs in the cycle `rst` falls.
- Fetch alone, MEM_LAT=2: `if_req`=1, `if_addr`=0x100 at cycle 0; memory returns 0x00500093 -> `if_gnt`=1, `mem_en`=1, `mem_addr`=0x100 at cycle 0. `if_rvalid`=1 with `if_rdata`=0x00500093 at cycle 2 only.
- Collision, MEM_LAT=1: both requests at cycle 0 (IF 0x4, DM read 0x80) -> `dm_gnt` at 0, `if_gnt` at 1. `dm_rvalid` at 1, `if_rvalid` at 2.
- Starvation, MEM_LAT=1, MAX_DWAIT=3: both requests held continuously -> grant sequence is D,D,D,F,D,D,D,F over cycles 0-7.
- Write: `dm_we`=1, `dm_addr`=0x40, `dm_wdata`=0xDEADBEEF -> in the grant cycle `mem_en`=1, `mem_we`=1, `mem_wdata`=0xDEADBEEF. `dm_rvalid`=1 with `dm_rdata`=0 at T+MEM_LAT.
- Reset mid-read, MEM_LAT=3: read granted at cycle 0, `rst`=1 at cycle 1 -> no `rvalid` at cycle 3; `busy`=0 from cycle 2.
